// File: rtl/qpu_mcu_measure_collect.sv
// Measurement collection unit: queues measurement groups, gathers out-of-order readout
// strobes and writes back the oldest group when it completes or times out.
module qpu_mcu_measure_collect #(
  parameter int unsigned QUBIT_NUM = 12,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned TIMEOUT   = 1023
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 meas_req_i_valid,
  input  logic [QUBIT_NUM-1:0] meas_req_i_list,
  output logic                 meas_req_i_ready,
  input  logic [QUBIT_NUM-1:0] adc_i_valid,
  input  logic [QUBIT_NUM-1:0] adc_i_data,
  output logic                 mcu_measure_o_wen,
  output logic [QUBIT_NUM-1:0] mcu_measure_o_data,
  output logic [QUBIT_NUM-1:0] mcu_measure_o_list,
  output logic                 mcu_measure_o_timeout,
  output logic                 mcu_drop_o,
  output logic                 mcu_busy_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned TmrW = $clog2(TIMEOUT + 1);

  logic [QUBIT_NUM-1:0] list_q [DEPTH];
  logic [QUBIT_NUM-1:0] list_d [DEPTH];
  logic [QUBIT_NUM-1:0] coll_q [DEPTH];
  logic [QUBIT_NUM-1:0] coll_d [DEPTH];
  logic [QUBIT_NUM-1:0] data_q [DEPTH];
  logic [QUBIT_NUM-1:0] data_d [DEPTH];
  logic [QUBIT_NUM-1:0] route  [DEPTH];

  logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]      count_q, count_d;
  logic [TmrW-1:0]      timer_q, timer_d;

  logic                 wen_q, wen_d, tmo_q, tmo_d, drop_q, drop_d;
  logic [QUBIT_NUM-1:0] out_list_q, out_list_d, out_data_q, out_data_d;

  logic                 full, push, pop, head_valid, head_done, head_tmo, drop;

  // Each strobe goes to the oldest pending entry still waiting on that qubit.
  always_comb begin
    logic            found;
    logic [PtrW-1:0] idx;
    found = 1'b0;
    idx   = '0;
    drop  = 1'b0;
    for (int i = 0; i < DEPTH; i++) route[i] = '0;
    for (int k = 0; k < QUBIT_NUM; k++) begin
      found = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        idx = rd_ptr_q + PtrW'(i);
        if (!found && adc_i_valid[k] && (CntW'(i) < count_q) &&
            list_q[idx][k] && !coll_q[idx][k]) begin
          route[idx][k] = 1'b1;
          found         = 1'b1;
        end
      end
      if (adc_i_valid[k] && !found) drop = 1'b1;
    end
  end

  assign full       = (count_q == CntW'(DEPTH));
  assign push       = meas_req_i_valid && !full && (|meas_req_i_list);
  assign head_valid = (count_q != '0);
  assign head_done  = head_valid &&
                      ((coll_q[rd_ptr_q] | route[rd_ptr_q]) == list_q[rd_ptr_q]);
  assign head_tmo   = head_valid && !head_done && (timer_q == TmrW'(TIMEOUT - 1));
  assign pop        = head_done || head_tmo;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      list_d[i] = list_q[i];
      coll_d[i] = coll_q[i] | route[i];
      data_d[i] = data_q[i] | (route[i] & adc_i_data);
    end
    // The write slot is never a pending entry, so routed bits cannot collide with it.
    if (push) begin
      list_d[wr_ptr_q] = meas_req_i_list;
      coll_d[wr_ptr_q] = '0;
      data_d[wr_ptr_q] = '0;
    end
    rd_ptr_d = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    count_d  = count_q + CntW'(push) - CntW'(pop);
    timer_d  = (pop || !head_valid) ? '0 : timer_q + TmrW'(1);

    wen_d      = pop;
    tmo_d      = head_tmo;
    drop_d     = drop;
    out_list_d = pop ? list_q[rd_ptr_q] : '0;
    out_data_d = pop ? (data_q[rd_ptr_q] | (route[rd_ptr_q] & adc_i_data)) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      list_q     <= '{default: '0};
      coll_q     <= '{default: '0};
      data_q     <= '{default: '0};
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      timer_q    <= '0;
      wen_q      <= 1'b0;
      tmo_q      <= 1'b0;
      drop_q     <= 1'b0;
      out_list_q <= '0;
      out_data_q <= '0;
    end else begin
      list_q     <= list_d;
      coll_q     <= coll_d;
      data_q     <= data_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      timer_q    <= timer_d;
      wen_q      <= wen_d;
      tmo_q      <= tmo_d;
      drop_q     <= drop_d;
      out_list_q <= out_list_d;
      out_data_q <= out_data_d;
    end
  end

  assign meas_req_i_ready      = !full;
  assign mcu_busy_o            = head_valid;
  assign mcu_measure_o_wen     = wen_q;
  assign mcu_measure_o_timeout = tmo_q;
  assign mcu_measure_o_list    = out_list_q;
  assign mcu_measure_o_data    = out_data_q;
  assign mcu_drop_o            = drop_q;

endmodule

// File: tb/tb_qpu_mcu_measure_collect.sv
// Bench for qpu_mcu_measure_collect: directed vector table, reset sequence and
// randomized traffic against a queue-based reference model.
module tb_qpu_mcu_measure_collect;

  localparam int Q = 12;
  localparam int D = 4;
  localparam int T = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         meas_req_i_valid = 1'b0;
  logic [Q-1:0] meas_req_i_list = '0;
  logic         meas_req_i_ready;
  logic [Q-1:0] adc_i_valid = '0;
  logic [Q-1:0] adc_i_data = '0;
  logic         mcu_measure_o_wen;
  logic [Q-1:0] mcu_measure_o_data;
  logic [Q-1:0] mcu_measure_o_list;
  logic         mcu_measure_o_timeout;
  logic         mcu_drop_o;
  logic         mcu_busy_o;

  qpu_mcu_measure_collect #(
    .QUBIT_NUM(Q),
    .DEPTH    (D),
    .TIMEOUT  (T)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .meas_req_i_valid     (meas_req_i_valid),
    .meas_req_i_list      (meas_req_i_list),
    .meas_req_i_ready     (meas_req_i_ready),
    .adc_i_valid          (adc_i_valid),
    .adc_i_data           (adc_i_data),
    .mcu_measure_o_wen    (mcu_measure_o_wen),
    .mcu_measure_o_data   (mcu_measure_o_data),
    .mcu_measure_o_list   (mcu_measure_o_list),
    .mcu_measure_o_timeout(mcu_measure_o_timeout),
    .mcu_drop_o           (mcu_drop_o),
    .mcu_busy_o           (mcu_busy_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         ready;
    logic         busy;
    logic         wen;
    logic         tmo;
    logic         drop;
    logic [Q-1:0] list;
    logic [Q-1:0] data;
  } obs_t;

  typedef struct {
    logic         rv;
    logic [Q-1:0] rl;
    logic [Q-1:0] av;
    logic [Q-1:0] ad;
    obs_t         exp;
  } vec_t;

  typedef struct {
    logic [Q-1:0] list;
    logic [Q-1:0] got;
    logic [Q-1:0] data;
  } grp_t;

  int   n_err = 0;
  int   n_chk = 0;
  vec_t tbl[$];
  grp_t mq[$];
  int   cyc = 0;
  int   head_since = 0;
  obs_t model_exp;

  function automatic obs_t mk(logic rdy, logic busy, logic wen, logic tmo, logic drop,
                              logic [Q-1:0] list, logic [Q-1:0] data);
    obs_t o;
    o.ready = rdy;
    o.busy  = busy;
    o.wen   = wen;
    o.tmo   = tmo;
    o.drop  = drop;
    o.list  = list;
    o.data  = data;
    return o;
  endfunction

  function automatic obs_t sample();
    return mk(meas_req_i_ready, mcu_busy_o, mcu_measure_o_wen, mcu_measure_o_timeout,
              mcu_drop_o, mcu_measure_o_list, mcu_measure_o_data);
  endfunction

  task automatic add(input logic rv, input logic [Q-1:0] rl, input logic [Q-1:0] av,
                     input logic [Q-1:0] ad, input obs_t exp);
    vec_t v;
    v.rv  = rv;
    v.rl  = rl;
    v.av  = av;
    v.ad  = ad;
    v.exp = exp;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input obs_t act, input obs_t exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got rdy=%b busy=%b wen=%b tmo=%b drop=%b list=%03h data=%03h, want rdy=%b busy=%b wen=%b tmo=%b drop=%b list=%03h data=%03h",
               name, act.ready, act.busy, act.wen, act.tmo, act.drop, act.list, act.data,
               exp.ready, exp.busy, exp.wen, exp.tmo, exp.drop, exp.list, exp.data);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    head_since = cyc;
  endtask

  // One clock edge of the reference: route strobes to the oldest waiting group, retire the
  // oldest group if complete or it has been at the head TIMEOUT cycles, then enqueue.
  task automatic model_step(input logic rv, input logic [Q-1:0] rl, input logic [Q-1:0] av,
                            input logic [Q-1:0] ad);
    bit   can_take;
    bit   hit;
    obs_t e;
    cyc++;
    can_take = (mq.size() < D);
    e = '0;
    for (int k = 0; k < Q; k++) begin
      if (av[k]) begin
        hit = 0;
        for (int i = 0; i < mq.size(); i++) begin
          if (!hit && mq[i].list[k] && !mq[i].got[k]) begin
            mq[i].got[k]  = 1'b1;
            mq[i].data[k] = ad[k];
            hit = 1;
          end
        end
        if (!hit) e.drop = 1'b1;
      end
    end
    if (mq.size() > 0) begin
      if (mq[0].got == mq[0].list || (cyc - head_since) == T) begin
        e.wen  = 1'b1;
        e.tmo  = (mq[0].got != mq[0].list);
        e.list = mq[0].list;
        e.data = mq[0].data;
        void'(mq.pop_front());
        head_since = cyc;
      end
    end
    if (rv && can_take && rl != '0) begin
      grp_t g;
      g.list = rl;
      g.got  = '0;
      g.data = '0;
      if (mq.size() == 0) head_since = cyc;
      mq.push_back(g);
    end
    e.busy = (mq.size() > 0);
    e.ready = (mq.size() < D);
    model_exp = e;
  endtask

  task automatic apply(input logic rv, input logic [Q-1:0] rl, input logic [Q-1:0] av,
                       input logic [Q-1:0] ad);
    meas_req_i_valid = rv;
    meas_req_i_list  = rl;
    adc_i_valid      = av;
    adc_i_data       = ad;
    model_step(rv, rl, av, ad);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [Q-1:0] pend, rl, av, ad;
    logic         rv;
    obs_t         idle_busy, idle_empty;
    idle_busy  = mk(1, 1, 0, 0, 0, 12'h000, 12'h000);
    idle_empty = mk(1, 0, 0, 0, 0, 12'h000, 12'h000);

    // Out-of-order completion
    add(1, 12'h005, 12'h000, 12'h000, idle_busy);
    add(0, 12'h000, 12'h004, 12'h004, idle_busy);
    add(0, 12'h000, 12'h000, 12'h000, idle_busy);
    add(0, 12'h000, 12'h001, 12'h000, mk(1, 0, 1, 0, 0, 12'h005, 12'h004));
    add(0, 12'h000, 12'h000, 12'h000, idle_empty);
    // Two overlapping groups on q0
    add(1, 12'h001, 12'h000, 12'h000, idle_busy);
    add(1, 12'h001, 12'h000, 12'h000, idle_busy);
    add(0, 12'h000, 12'h001, 12'h001, mk(1, 1, 1, 0, 0, 12'h001, 12'h001));
    add(0, 12'h000, 12'h001, 12'h000, mk(1, 0, 1, 0, 0, 12'h001, 12'h000));
    add(0, 12'h000, 12'h000, 12'h000, idle_empty);
    // Full FIFO: fifth request held, taken only after the first retire
    add(1, 12'h001, 12'h000, 12'h000, idle_busy);
    add(1, 12'h002, 12'h000, 12'h000, idle_busy);
    add(1, 12'h004, 12'h000, 12'h000, idle_busy);
    add(1, 12'h008, 12'h000, 12'h000, mk(0, 1, 0, 0, 0, 12'h000, 12'h000));
    add(1, 12'h010, 12'h001, 12'h001, mk(1, 1, 1, 0, 0, 12'h001, 12'h001));
    add(1, 12'h010, 12'h000, 12'h000, mk(0, 1, 0, 0, 0, 12'h000, 12'h000));
    add(0, 12'h000, 12'h01E, 12'h01E, mk(1, 1, 1, 0, 0, 12'h002, 12'h002));
    add(0, 12'h000, 12'h000, 12'h000, mk(1, 1, 1, 0, 0, 12'h004, 12'h004));
    add(0, 12'h000, 12'h000, 12'h000, mk(1, 1, 1, 0, 0, 12'h008, 12'h008));
    add(0, 12'h000, 12'h000, 12'h000, mk(1, 0, 1, 0, 0, 12'h010, 12'h010));
    add(0, 12'h000, 12'h000, 12'h000, idle_empty);
    // Timeout: retire 8 cycles after becoming head, late q1 strobe drops
    add(1, 12'h003, 12'h000, 12'h000, idle_busy);
    add(0, 12'h000, 12'h001, 12'h001, idle_busy);
    for (int i = 0; i < 6; i++) add(0, 12'h000, 12'h000, 12'h000, idle_busy);
    add(0, 12'h000, 12'h000, 12'h000, mk(1, 0, 1, 1, 0, 12'h003, 12'h001));
    add(0, 12'h000, 12'h002, 12'h002, mk(1, 0, 0, 0, 1, 12'h000, 12'h000));
    add(0, 12'h000, 12'h000, 12'h000, idle_empty);
    // Orphan strobe and zero-list request
    add(0, 12'h000, 12'h020, 12'h020, mk(1, 0, 0, 0, 1, 12'h000, 12'h000));
    add(1, 12'h000, 12'h000, 12'h000, idle_empty);
    add(0, 12'h000, 12'h000, 12'h000, idle_empty);

    #3;
    chk("reset_state", sample(), idle_empty);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_reset();

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].rv, tbl[i].rl, tbl[i].av, tbl[i].ad);
      chk($sformatf("tbl%0d", i), sample(), tbl[i].exp);
    end

    // Reset mid-operation while a write-back pulse is on the outputs
    apply(1, 12'h001, 12'h000, 12'h000);
    apply(1, 12'h002, 12'h000, 12'h000);
    apply(1, 12'h004, 12'h001, 12'h001);
    chk("pre_reset_wen", sample(), mk(1, 1, 1, 0, 0, 12'h001, 12'h001));
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_reset", sample(), idle_empty);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    apply(0, 12'h000, 12'h002, 12'h002);
    chk("post_reset_drop_q1", sample(), mk(1, 0, 0, 0, 1, 12'h000, 12'h000));
    apply(0, 12'h000, 12'h004, 12'h000);
    chk("post_reset_drop_q2", sample(), mk(1, 0, 0, 0, 1, 12'h000, 12'h000));
    apply(0, 12'h000, 12'h000, 12'h000);
    chk("post_reset_idle", sample(), idle_empty);

    // Randomized traffic, strobes biased toward qubits still pending
    for (int n = 0; n < 3000; n++) begin
      pend = '0;
      for (int i = 0; i < mq.size(); i++) pend |= mq[i].list & ~mq[i].got;
      rv = ($urandom_range(0, 2) == 0);
      rl = Q'($urandom) & Q'($urandom);
      av = (pend & Q'($urandom) & Q'($urandom)) |
           (Q'($urandom) & Q'($urandom) & Q'($urandom) & Q'($urandom));
      ad = Q'($urandom);
      apply(rv, rl, av, ad);
      chk($sformatf("rand%0d", n), sample(), model_exp);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/qpu_mcu_measure_collect.md
# qpu_mcu_measure_collect

Measurement collection unit on the producer side of the measurement-result write port. It records each issued measurement event as a pending qubit group and gathers the per-qubit readout bits as they arrive out of order. When every qubit of the oldest group has reported, or the group times out, it drives one write-back pulse to the execution-unit register file. That pulse carries the result bits and the qubit list that controls which measurement registers get written.

## Interface
- QUBIT_NUM, 12: number of qubits; width of all lists and data.
- DEPTH, 4: outstanding measurement groups; power of two, at least 2.
- TIMEOUT, 1023: cycles a group may sit at the head before forced retire; at least 2.
- Clock and reset: one clock, `clk`. Reset `rst_n` is asynchronous and active-low.
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- meas_req_i_valid  in  1  measurement event issued
- meas_req_i_list  in  QUBIT_NUM  qubits measured by this event
- meas_req_i_ready  out  1  request accepted when valid&ready
- adc_i_valid  in  QUBIT_NUM  per-qubit result strobe, one cycle
- adc_i_data  in  QUBIT_NUM  per-qubit result bit, qualified by adc_i_valid[k]
- mcu_measure_o_wen  out  1  one-cycle write-back pulse
- mcu_measure_o_data  out  QUBIT_NUM  result bits, 0 where not measured or missing
- mcu_measure_o_list  out  QUBIT_NUM  qubit list of the retired group
- mcu_measure_o_timeout  out  1  qualifies wen: group retired by timeout
- mcu_drop_o  out  1  pulse: at least one strobe matched no pending qubit
- mcu_busy_o  out  1  at least one group pending

## Operation
- FIFO of DEPTH entries. Each entry holds a list, a collected mask and a data register. The head is the oldest entry.
- meas_req_i_ready = ~full.
- Accepting a request with a nonzero list enqueues it with collected=0 and data=0.
- Accepting a request with an all-zero list has ready high, but the request is discarded and not enqueued.
- Strobe routing: adc_i_valid[k] goes to the oldest valid entry with list[k]=1 and collected[k]=0. That entry sets collected[k] and data[k]=adc_i_data[k].
- If no entry matches a strobe, the strobe is dropped and mcu_drop_o pulses in the next cycle.
- Strobes never match an entry that is being enqueued in the same cycle.
- Head completion: the head completes when (collected | this-cycle routed strobes) == list. The head pops at that edge, including the data from this cycle's strobes.
- Timeout: a counter clears whenever a new entry becomes head and increments each cycle the head is valid and not complete.
  - When the counter equals TIMEOUT-1 and the head is still incomplete, the head pops.
  - The popped entry keeps its collected data; missing bits are 0. mcu_measure_o_timeout=1.
  - A strobe for a timed-out qubit arriving later follows the normal routing rule (next matching entry, or drop).
- Only the head can retire, at most one entry per cycle. An entry behind the head that is already complete retires in the cycle after it becomes head.
- Simultaneous enqueue and pop: allowed. When full, ready is low even if a pop occurs that cycle.
- mcu_busy_o = FIFO not empty.

## Timing
- Reset values: all outputs 0 except meas_req_i_ready=1. FIFO is empty and the counter is 0. Asserting rst_n low mid-operation discards all pending groups with no write-back.
- Outputs mcu_measure_o_* and mcu_drop_o are registered.
- Completion latency: if the final strobe of the head is sampled at edge E, then mcu_measure_o_wen is high for exactly one cycle after E.
- Request to strobe: a request accepted at edge E can match strobes sampled at E+1 or later.
- Write-back pulse: wen is never high two cycles running for the same group. data and list are valid only while wen=1 and are 0 otherwise.
- Timeout pulse: wen and timeout rise together, TIMEOUT cycles after the group became head.

## Test plan
- Out-of-order completion, TIMEOUT=8:
  - Stimulus: request list=0x005. Strobe q2 with data 1 one cycle later. Strobe q0 with data 0 three cycles later.
  - Required: one wen pulse, list=0x005, data=0x004, timeout=0, in the cycle after the q0 strobe.
- Two overlapping groups on the same qubit:
  - Stimulus: requests 0x001 then 0x001. Strobe q0 with 1, then strobe q0 with 0.
  - Required: wen with data=0x001, then wen with data=0x000, in order. No drop.
- Full FIFO, DEPTH=4:
  - Stimulus: four requests, then hold valid for a fifth.
  - Required: ready=0 after the fourth is accepted. The fifth is accepted only in the cycle after the first retire.
- Timeout, TIMEOUT=8:
  - Stimulus: request 0x003, strobe only q0 with 1.
  - Required: wen=1, timeout=1, data=0x001, list=0x003, exactly 8 cycles after the group became head. A later q1 strobe produces mcu_drop_o=1.
- Orphan strobe and zero list:
  - Stimulus: a strobe on q5 with no pending group.
  - Required: mcu_drop_o pulses. A request with list=0 is accepted and produces no wen.
- Reset mid-operation:
  - Stimulus: two groups pending, assert rst_n low.
  - Required: all outputs 0 immediately and ready=1. After release, strobes drop.
